mem_access_unit: RTL and testbench

// - Memory stage of the RV32I core; issues loads and stores to the data memory over a req/ready + rvalid handshake.
// - Sources the load data that writeback selects on mem_read, and stalls the pipeline while an access is in flight.
// - Stores: byte-lane steering and write mask. Loads: alignment, sign/zero extension, misalign/illegal/timeout faults.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the RV32I memory stage.
//   - funct3 encodings for the load/store access sizes
//   - fault cause codes reported on o_fault_cause
//   - mau_state_t, the memory access unit state encoding
//   - small classification helpers used when a new access is presented
package rv_pkg;

  // Load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fault cause codes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } mau_state_t;

  // Stores only exist in B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/halfword out of a 32-bit read word
// and sign- or zero-extends it according to funct3. Purely combinational.
// Ports:
//   i_rdata   in  32  word returned by memory
//   i_addr_lo in  2   low address bits of the access
//   i_funct3  in  3   load size/sign
//   o_data    out 32  extended load result
module mem_load_align
  import rv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection: byte by both low bits, halfword by addr[1] only
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
  end

  // Extension according to access type
  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I memory stage. Accepts one load/store from execute,
// issues it to data memory over a req/ready + rvalid handshake, stalls the
// pipeline while the access is in flight and returns extended load data.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_valid               execute presents a memory instruction
//   i_mem_read/i_mem_write  load / store
//   i_funct3, i_addr, i_store_data  access description
//   o_busy                stall request
//   o_done, o_fault       completion pulse, fault pulse (with o_done)
//   o_mem_data_out        load result, held until the next o_done
//   o_fault_cause         00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   o_dmem_*              request channel to data memory (word address, mask)
//   i_dmem_ready          memory accepts the request
//   i_dmem_rvalid/rdata   read response
module mem_access_unit
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_mem_data_out,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  // Counter value in the last allowed REQ/WAIT cycle
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 32'd0);

  mau_state_t        r_state;
  mau_state_t        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_store;
  logic [31:0]       r_addr;
  logic [1:0]        r_addr_lo;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic [3:0]        r_mask;
  logic              r_done;
  logic              r_fault;
  logic [1:0]        r_cause;
  logic [31:0]       r_data_out;

  logic              w_start;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_timeout;
  logic [31:0]       w_load_word;
  logic [31:0]       w_st_wdata;
  logic [3:0]        w_st_mask;

  // Classification of the instruction presented by execute
  always_comb begin
    w_start    = i_valid & (i_mem_read | i_mem_write);
    w_illegal  = ~f3_legal(i_funct3, i_mem_write);
    w_misalign = f3_misaligned(i_funct3, i_addr[1:0]);
    w_timeout  = TO_EN && (r_cnt == TO_LAST);
  end

  // Store lane steering: data replicated across lanes, mask selects the bytes
  always_comb begin
    case (i_funct3)
      F3_B: begin
        w_st_wdata = {4{i_store_data[7:0]}};
        w_st_mask  = 4'b0001 << i_addr[1:0];
      end
      F3_H: begin
        w_st_wdata = {2{i_store_data[15:0]}};
        w_st_mask  = 4'b0011 << {i_addr[1], 1'b0};
      end
      default: begin
        w_st_wdata = i_store_data;
        w_st_mask  = 4'b1111;
      end
    endcase
  end

  mem_load_align u_load_align (
    .i_rdata   (i_dmem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_word)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a completion in the final cycle wins over timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start && !w_illegal && !w_misalign) begin
          w_next_state = REQ;
        end else begin
          w_next_state = IDLE;
        end
      end
      REQ: begin
        if (i_dmem_ready) begin
          w_next_state = r_is_store ? IDLE : WAIT;
        end else if (w_timeout) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = REQ;
        end
      end
      WAIT: begin
        if (i_dmem_rvalid || w_timeout) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: stall and request strobe
  always_comb begin
    case (r_state)
      IDLE: begin
        o_busy     = w_start;
        o_dmem_req = 1'b0;
      end
      REQ: begin
        o_busy     = 1'b1;
        o_dmem_req = 1'b1;
      end
      WAIT: begin
        o_busy     = 1'b1;
        o_dmem_req = 1'b0;
      end
      default: begin
        o_busy     = 1'b0;
        o_dmem_req = 1'b0;
      end
    endcase
  end

  // Timeout counter: held at zero in IDLE so entering REQ starts from zero
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Request latching, completion/fault pulses and held result registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_is_store <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_addr_lo  <= 2'b00;
      r_funct3   <= 3'b000;
      r_wdata    <= 32'h0000_0000;
      r_mask     <= 4'b0000;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_cause    <= CAUSE_NONE;
      r_data_out <= 32'h0000_0000;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_illegal) begin
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_cause <= CAUSE_ILLEGAL;
            end else if (w_misalign) begin
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_cause <= CAUSE_MISALIGN;
            end else begin
              r_is_store <= i_mem_write;
              r_addr     <= {i_addr[31:2], 2'b00};
              r_addr_lo  <= i_addr[1:0];
              r_funct3   <= i_funct3;
              r_wdata    <= i_mem_write ? w_st_wdata : 32'h0000_0000;
              r_mask     <= i_mem_write ? w_st_mask : 4'b1111;
            end
          end
        end
        REQ: begin
          if (i_dmem_ready) begin
            if (r_is_store) begin
              r_done  <= 1'b1;
              r_cause <= CAUSE_NONE;
            end
          end else if (w_timeout) begin
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            r_done     <= 1'b1;
            r_cause    <= CAUSE_NONE;
            r_data_out <= w_load_word;
          end else if (w_timeout) begin
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign o_done         = r_done;
  assign o_fault        = r_fault;
  assign o_fault_cause  = r_cause;
  assign o_mem_data_out = r_data_out;
  assign o_dmem_we      = r_is_store;
  assign o_dmem_addr    = r_addr;
  assign o_dmem_wdata   = r_wdata;
  assign o_dmem_mask    = r_mask;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores against a behavioural reference model of the access rules.
module tb_mem_access_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_mem_data_out;
  logic        o_fault;
  logic [1:0]  o_fault_cause;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  int n_tests;
  int n_fail;
  logic [31:0] exp_data;
  logic [1:0]  exp_cause;

  mem_access_unit #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_funct3       (i_funct3),
    .i_addr         (i_addr),
    .i_store_data   (i_store_data),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_mem_data_out (o_mem_data_out),
    .o_fault        (o_fault),
    .o_fault_cause  (o_fault_cause),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_dmem_addr    (o_dmem_addr),
    .o_dmem_wdata   (o_dmem_wdata),
    .o_dmem_mask    (o_dmem_mask),
    .i_dmem_ready   (i_dmem_ready),
    .i_dmem_rvalid  (i_dmem_rvalid),
    .i_dmem_rdata   (i_dmem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    int lo;
    n  = ref_size(f3);
    lo = int'(addr % 32'd4);
    return 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n;
    logic [31:0] w;
    n = ref_size(f3);
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      w = w | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int lo;
    int v;
    logic [31:0] sh;
    lo = int'(addr % 32'd4);
    sh = word >> (8 * lo);
    case (f3)
      3'd0: begin
        v = int'(sh & 32'hFF);
        if (v >= 128) v = v - 256;
        return 32'(v);
      end
      3'd1: begin
        v = int'(sh & 32'hFFFF);
        if (v >= 32768) v = v - 65536;
        return 32'(v);
      end
      3'd4:    return sh & 32'hFF;
      3'd5:    return sh & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  // One access starting in the current (post-negedge) cycle; ends at the
  // negedge of the o_done cycle so a following call is back-to-back.
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input int rdy, input int rv,
                            input logic [31:0] rdata);
    bit legal;
    bit mis;
    legal = ref_legal(st, f3);
    mis   = legal && ((addr % 32'(ref_size(f3))) != 32'd0);
    i_valid      = 1'b1;
    i_mem_read   = !st;
    i_mem_write  = st;
    i_funct3     = f3;
    i_addr       = addr;
    i_store_data = sd;
    #1;
    check("busy_on_start", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    if (!legal || mis) begin
      exp_cause = !legal ? 2'b11 : 2'b01;
      check("fault_no_req", 32'(o_dmem_req), 32'd0);
      check("fault_done", 32'(o_done), 32'd1);
      check("fault_flag", 32'(o_fault), 32'd1);
      check("fault_cause", 32'(o_fault_cause), 32'(exp_cause));
      check("fault_data_held", o_mem_data_out, exp_data);
      check("fault_busy_low", 32'(o_busy), 32'd0);
      return;
    end
    for (int k = 0; k <= rdy; k++) begin
      check("req_high", 32'(o_dmem_req), 32'd1);
      check("req_busy", 32'(o_busy), 32'd1);
      check("req_no_done", 32'(o_done), 32'd0);
      check("req_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
      check("req_we", 32'(o_dmem_we), 32'(st));
      check("req_mask", 32'(o_dmem_mask), st ? 32'(ref_mask(f3, addr)) : 32'hF);
      if (st) check("req_wdata", o_dmem_wdata, ref_wdata(f3, sd));
      // stalled pipeline keeps presenting instructions; they must be ignored
      i_valid    = 1'($urandom);
      i_mem_read = 1'b1;
      i_funct3   = 3'($urandom);
      i_addr     = $urandom;
      i_dmem_ready = (k == rdy);
      @(negedge i_clk);
      i_dmem_ready = 1'b0;
    end
    if (!st) begin
      for (int k = 0; k <= rv; k++) begin
        check("wait_no_req", 32'(o_dmem_req), 32'd0);
        check("wait_busy", 32'(o_busy), 32'd1);
        check("wait_no_done", 32'(o_done), 32'd0);
        i_valid       = 1'($urandom);
        i_dmem_rvalid = (k == rv);
        i_dmem_rdata  = (k == rv) ? rdata : $urandom;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
      end
      exp_data = ref_load(f3, addr, rdata);
    end
    exp_cause = 2'b00;
    i_valid = 1'b0;
    #1;
    check("done_pulse", 32'(o_done), 32'd1);
    check("done_no_fault", 32'(o_fault), 32'd0);
    check("done_cause", 32'(o_fault_cause), 32'(exp_cause));
    check("done_data", o_mem_data_out, exp_data);
    check("done_req_low", 32'(o_dmem_req), 32'd0);
    check("done_busy_low", 32'(o_busy), 32'd0);
  endtask

  int cnt;

  initial begin
    n_tests = 0;
    n_fail = 0;
    exp_data = 32'd0;
    exp_cause = 2'b00;
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_mem_read = 1'b0;
    i_mem_write = 1'b0;
    i_funct3 = 3'b000;
    i_addr = 32'd0;
    i_store_data = 32'd0;
    i_dmem_ready = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata = 32'd0;
    #1;
    check("rst_req", 32'(o_dmem_req), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_data", o_mem_data_out, 32'd0);
    check("rst_cause", 32'(o_fault_cause), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);

    // directed cases
    run_access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 2, 3, 32'hDEAD_BEEF);
    check("lw_const", o_mem_data_out, 32'hDEAD_BEEF);
    @(negedge i_clk);
    check("lw_single_pulse", 32'(o_done), 32'd0);
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 1, 32'h80FF_0000);
    check("lb_const", o_mem_data_out, 32'hFFFF_FF80);
    run_access(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1, 0, 32'h80FF_0000);
    check("lbu_const", o_mem_data_out, 32'h0000_0080);
    run_access(1'b0, 3'b101, 32'h0000_0102, 32'd0, 0, 0, 32'h80FF_0000);
    check("lhu_const", o_mem_data_out, 32'h0000_80FF);
    run_access(1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 1, 0, 32'd0);
    check("sh_data_unchanged", o_mem_data_out, 32'h0000_80FF);
    run_access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 0, 32'd0);
    check("misalign_cause", 32'(o_fault_cause), 32'd1);
    run_access(1'b0, 3'b011, 32'h0000_0100, 32'd0, 0, 0, 32'd0);
    check("illegal_cause", 32'(o_fault_cause), 32'd3);

    // timeout in REQ: ready never given
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
    i_funct3 = 3'b010; i_addr = 32'h0000_0300;
    @(negedge i_clk);
    i_valid = 1'b0;
    cnt = 0;
    while (o_dmem_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge i_clk);
    end
    check("to_req_cycles", 32'(cnt), 32'd8);
    check("to_done", 32'(o_done), 32'd1);
    check("to_fault", 32'(o_fault), 32'd1);
    check("to_cause", 32'(o_fault_cause), 32'd2);
    check("to_data_held", o_mem_data_out, exp_data);
    run_access(1'b0, 3'b010, 32'h0000_0304, 32'd0, 1, 1, 32'hCAFE_F00D);

    // timeout in WAIT: accepted in first REQ cycle, rvalid never arrives
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
    i_funct3 = 3'b010; i_addr = 32'h0000_0308;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_dmem_ready = 1'b1;
    @(negedge i_clk);
    i_dmem_ready = 1'b0;
    cnt = 0;
    while (o_busy === 1'b1 && o_done !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge i_clk);
    end
    check("to_wait_cycles", 32'(cnt), 32'd7);
    check("to_wait_fault", 32'(o_fault), 32'd1);
    check("to_wait_cause", 32'(o_fault_cause), 32'd2);
    check("to_wait_data", o_mem_data_out, 32'hCAFE_F00D);

    // reset during WAIT, then a stray rvalid
    @(negedge i_clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
    i_funct3 = 3'b010; i_addr = 32'h0000_0400;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_dmem_ready = 1'b1;
    @(negedge i_clk);
    i_dmem_ready = 1'b0;
    i_rst = 1'b0;
    #1;
    check("rst_mid_req", 32'(o_dmem_req), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_done", 32'(o_done), 32'd0);
    check("rst_mid_data", o_mem_data_out, 32'd0);
    check("rst_mid_addr", o_dmem_addr, 32'd0);
    check("rst_mid_mask", 32'(o_dmem_mask), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = 32'h5555_AAAA;
    @(negedge i_clk);
    i_dmem_rvalid = 1'b0;
    check("stray_rvalid_done", 32'(o_done), 32'd0);
    check("stray_rvalid_data", o_mem_data_out, 32'd0);
    exp_data = 32'd0;
    exp_cause = 2'b00;
    run_access(1'b0, 3'b010, 32'h0000_0404, 32'd0, 0, 2, 32'h0BAD_C0DE);

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      bit st;
      logic [2:0] f3;
      logic [31:0] a;
      int gap;
      st  = 1'($urandom);
      f3  = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
            (st ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2))
                                                                          : 3'($urandom_range(4, 5))));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(ref_size(f3)) - 32'd1);
      run_access(st, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge i_clk);
        check("idle_no_done", 32'(o_done), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
